mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle main controller for the single-memory MIPS datapath. It latches nothing itself: it sequences FETCH/DECODE/EXE/MEM/WB per instruction, decodes the IR contents (Instr) into the datapath control fields, and gates every write strobe by state. It extends the base subset (addu, subu, ori, lui, lw, sw, beq, j, jal, jr) with mult, div, mfhi and mflo. These are backed by a parametrised multiply/divide busy counter, with stall on memory-not-ready and on HI/LO busy.

Parameters:
MULT_CYCLES, 5, cycles mult occupies the MD unit after md_start (1..2^CNT_W-1)
DIV_CYCLES, 10, cycles div occupies the MD unit after md_start (1..2^CNT_W-1)
CNT_W, 4, width of MD busy counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
Instr  in  32  IR contents; valid from DECODE onward
mem_rdy  in  1  memory completes the current access this cycle
zero  in  1  ALU equality flag, for beq
PCWrite  out  1  PC load strobe
IRWrite  out  1  IR load strobe
RegWrite  out  1  GRF write strobe
MemWrite  out  1  DM write strobe
A3  out  5  GRF write address
ALUSrc  out  1  0=rt, 1=ext imm
MemtoReg  out  2  0=ALU, 1=DM, 2=PC+4, 3=HI/LO
hilo_sel  out  1  0=LO, 1=HI (mflo/mfhi)
nPC_sel  out  2  0=PC+4, 1=branch, 2=j/jal target, 3=rs (jr)
ExtOp  out  2  0=zero-ext, 1=sign-ext, 2=lui shift
ALUctr  out  3  0=add, 1=sub, 2=or, 3=eq-compare
md_start  out  1  one-cycle start pulse to MD unit
md_op  out  1  0=mult, 1=div
md_busy  out  1  MD counter nonzero
state  out  3  0=FETCH, 1=DECODE, 2=EXE, 3=MEM, 4=WB
instr_done  out  1  pulse on the last cycle of each instruction

Behaviour:
- Decode: op=Instr[31:26], func=Instr[5:0]. mult = op 0/func 011000, div = op 0/func 011010, mfhi = op 0/func 010000, mflo = op 0/func 010010. The base subset uses its standard MIPS encodings.
- Decode fields (A3, ALUSrc, MemtoReg, hilo_sel, ExtOp, ALUctr, md_op) are combinational from Instr in DECODE..WB and forced to 0 in FETCH.
- A3: rd for addu/subu/mfhi/mflo; rt for ori/lw/lui; 31 for jal; else 0.
- ALUSrc=1 for ori/lui/lw/sw. ExtOp=1 for lw/sw, 2 for lui. ALUctr=1 subu, 2 ori, 3 beq, else 0.
- Strobes (PCWrite, IRWrite, RegWrite, MemWrite, md_start, instr_done) are asserted only as listed below. They are 0 in all other cases and 0 whenever reset=1.
- nPC_sel is 0 except as listed below.
- FETCH: if mem_rdy, assert IRWrite=1 and PCWrite=1 (nPC_sel=0), then go to DECODE. Otherwise hold in FETCH.
- DECODE:
  - j: PCWrite=1, nPC_sel=2, go to FETCH.
  - jal: same as j, plus RegWrite=1, A3=31, MemtoReg=2.
  - jr: PCWrite=1, nPC_sel=3, go to FETCH.
  - mfhi/mflo: if md_busy, hold in DECODE; else go to WB.
  - undefined encoding: treated as nop, go to FETCH.
  - all others: go to EXE.
  - instr_done=1 on every DECODE→FETCH transition.
- EXE:
  - beq: ALUctr=3; if zero, PCWrite=1 and nPC_sel=1. Go to FETCH with instr_done=1.
  - mult/div: if md_busy, hold in EXE. Else md_start=1 (one cycle) and go to FETCH with instr_done=1.
  - lw/sw: go to MEM.
  - addu/subu/ori/lui: go to WB.
- MEM:
  - sw: MemWrite=1 on every MEM cycle. When mem_rdy, go to FETCH with instr_done=1.
  - lw: when mem_rdy, go to WB.
  - Without mem_rdy, hold in MEM indefinitely.
- WB: RegWrite=1 for exactly one cycle, then go to FETCH with instr_done=1. MemtoReg: lw=1, mfhi/mflo=3, else 0.
- MD counter:
  - On md_start, load MULT_CYCLES (md_op=0) or DIV_CYCLES (md_op=1).
  - Otherwise decrement while nonzero; saturate at 0.
  - md_busy = (cnt != 0), taken directly from the register, so it is high from the cycle after md_start for exactly N cycles.
  - Unrelated instructions continue executing while md_busy is high. Only mult/div/mfhi/mflo stall.
- Reset: at the edge, state←FETCH and cnt←0, regardless of current state (this includes MEM with sw pending, and an active MD count). Strobes are forced low combinationally while reset=1.
- Latency, with mem_rdy=1 throughout:
  - j/jal/jr: 2 cycles
  - beq/mult/div: 3 cycles
  - R-type/ori/lui/sw: 4 cycles
  - lw: 5 cycles
  - mfhi/mflo (not busy): 3 cycles

Test Plan:
1. Reset mid-MEM of sw with mem_rdy=0, then release → state=0, MemWrite=0 during and after reset, md_busy=0; the first FETCH with mem_rdy=1 gives IRWrite=PCWrite=1.
2. addu $3,$1,$2 (0x00221821), mem_rdy=1 → states 0,1,2,4; in WB RegWrite=1, A3=3, MemtoReg=0, ALUctr=0; instr_done on cycle 4.
3. lw with mem_rdy low for 3 MEM cycles → state stays 3 for 3 cycles, then WB with MemtoReg=1, A3=rt, ExtOp=1; total 8 cycles.
4. beq with zero=1, then with zero=0 → in EXE nPC_sel=1 and PCWrite=1 in the first case; PCWrite=0 and nPC_sel=0 in the second.
5. div (DIV_CYCLES=10), then addu, then mfhi immediately → md_start pulses once with md_op=1; addu completes without stall; mfhi holds in DECODE until md_busy falls (10 cycles after start), then WB with MemtoReg=3, hilo_sel=1.
6. mult issued while a prior mult is busy (MULT_CYCLES=5) → EXE holds until cnt=0; md_start is never asserted while md_busy=1.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the single-memory MIPS datapath.
// Sequences FETCH/DECODE/EXE/MEM/WB, decodes Instr into control fields and paces the mult/div unit.
module mc_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        mem_rdy,
    input  logic        zero,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [4:0]  A3,
    output logic        ALUSrc,
    output logic [1:0]  MemtoReg,
    output logic        hilo_sel,
    output logic [1:0]  nPC_sel,
    output logic [1:0]  ExtOp,
    output logic [2:0]  ALUctr,
    output logic        md_start,
    output logic        md_op,
    output logic        md_busy,
    output logic [2:0]  state,
    output logic        instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    logic [5:0] w_op;
    logic [5:0] w_func;
    logic       w_rtype;
    logic       w_addu, w_subu, w_jr, w_mult, w_div, w_mfhi, w_mflo;
    logic       w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic       w_known;
    logic       w_unused_fields;

    logic       w_pc_write, w_ir_write, w_reg_write, w_mem_write, w_md_start, w_done;

    assign w_op    = Instr[31:26];
    assign w_func  = Instr[5:0];
    assign w_rtype = (w_op == 6'b000000);

    // rs and shamt feed the datapath directly; the controller never looks at them.
    assign w_unused_fields = ^{Instr[25:21], Instr[10:6]};

    assign w_addu = w_rtype && (w_func == 6'b100001);
    assign w_subu = w_rtype && (w_func == 6'b100011);
    assign w_jr   = w_rtype && (w_func == 6'b001000);
    assign w_mult = w_rtype && (w_func == 6'b011000);
    assign w_div  = w_rtype && (w_func == 6'b011010);
    assign w_mfhi = w_rtype && (w_func == 6'b010000);
    assign w_mflo = w_rtype && (w_func == 6'b010010);
    assign w_ori  = (w_op == 6'b001101);
    assign w_lui  = (w_op == 6'b001111);
    assign w_lw   = (w_op == 6'b100011);
    assign w_sw   = (w_op == 6'b101011);
    assign w_beq  = (w_op == 6'b000100);
    assign w_j    = (w_op == 6'b000010);
    assign w_jal  = (w_op == 6'b000011);

    assign w_known = w_addu | w_subu | w_jr | w_mult | w_div | w_mfhi | w_mflo |
                     w_ori | w_lui | w_lw | w_sw | w_beq | w_j | w_jal;

    assign md_busy = (r_cnt != '0);
    assign state   = r_state;

    // The IR is stale during FETCH, so every decode field is held at zero there.
    always_comb begin
        A3       = 5'd0;
        ALUSrc   = 1'b0;
        MemtoReg = 2'd0;
        hilo_sel = 1'b0;
        ExtOp    = 2'd0;
        ALUctr   = 3'd0;
        md_op    = 1'b0;
        if (r_state != S_FETCH) begin
            if (w_addu || w_subu || w_mfhi || w_mflo) A3 = Instr[15:11];
            else if (w_ori || w_lw || w_lui)         A3 = Instr[20:16];
            else if (w_jal)                          A3 = 5'd31;

            ALUSrc = w_ori | w_lui | w_lw | w_sw;

            if (w_jal)                 MemtoReg = 2'd2;
            else if (w_lw)             MemtoReg = 2'd1;
            else if (w_mfhi || w_mflo) MemtoReg = 2'd3;

            hilo_sel = w_mfhi;

            if (w_lw || w_sw) ExtOp = 2'd1;
            else if (w_lui)   ExtOp = 2'd2;

            if (w_subu)      ALUctr = 3'd1;
            else if (w_ori)  ALUctr = 3'd2;
            else if (w_beq)  ALUctr = 3'd3;

            md_op = w_div;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_md_start  = 1'b0;
        w_done      = 1'b0;
        nPC_sel     = 2'd0;
        unique case (r_state)
            S_FETCH: begin
                if (mem_rdy) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_j || w_jal) begin
                    w_pc_write  = 1'b1;
                    nPC_sel     = 2'd2;
                    w_reg_write = w_jal;
                    w_done      = 1'b1;
                    w_next      = S_FETCH;
                end else if (w_jr) begin
                    w_pc_write = 1'b1;
                    nPC_sel    = 2'd3;
                    w_done     = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_mfhi || w_mflo) begin
                    if (!md_busy) w_next = S_WB;
                end else if (!w_known) begin
                    w_done = 1'b1;
                    w_next = S_FETCH;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                if (w_beq) begin
                    if (zero) begin
                        w_pc_write = 1'b1;
                        nPC_sel    = 2'd1;
                    end
                    w_done = 1'b1;
                    w_next = S_FETCH;
                end else if (w_mult || w_div) begin
                    if (!md_busy) begin
                        w_md_start = 1'b1;
                        w_done     = 1'b1;
                        w_next     = S_FETCH;
                    end
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_write = w_sw;
                if (mem_rdy) begin
                    if (w_sw) begin
                        w_done = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes drop combinationally while reset is held, even before the state register clears.
    assign PCWrite    = w_pc_write  & ~reset;
    assign IRWrite    = w_ir_write  & ~reset;
    assign RegWrite   = w_reg_write & ~reset;
    assign MemWrite   = w_mem_write & ~reset;
    assign md_start   = w_md_start  & ~reset;
    assign instr_done = w_done      & ~reset;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (md_start)
                r_cnt <= md_op ? DIV_LOAD : MULT_LOAD;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: reset, instruction sequencing, memory and MD stalls.
module tb_mc_ctrl;

    localparam logic [31:0] I_ADDU = 32'h0022_1821; // addu $3,$1,$2
    localparam logic [31:0] I_LW   = 32'h8C25_0004; // lw   $5,4($1)
    localparam logic [31:0] I_SW   = 32'hAC25_0008; // sw   $5,8($1)
    localparam logic [31:0] I_BEQ  = 32'h1022_0003; // beq  $1,$2,3
    localparam logic [31:0] I_DIV  = 32'h0022_001A; // div  $1,$2
    localparam logic [31:0] I_MULT = 32'h0022_0018; // mult $1,$2
    localparam logic [31:0] I_MFHI = 32'h0000_2010; // mfhi $4
    localparam logic [31:0] I_JAL  = 32'h0C00_0040; // jal  0x100
    localparam logic [31:0] I_JR   = 32'h03E0_0008; // jr   $31
    localparam logic [31:0] I_ORI  = 32'h3427_00FF; // ori  $7,$1,0xff
    localparam logic [31:0] I_LUI  = 32'h3C08_1234; // lui  $8,0x1234
    localparam logic [31:0] I_UND  = 32'hFC00_0000; // undefined opcode

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        mem_rdy;
    logic        zero;
    logic        PCWrite, IRWrite, RegWrite, MemWrite;
    logic [4:0]  A3;
    logic        ALUSrc;
    logic [1:0]  MemtoReg;
    logic        hilo_sel;
    logic [1:0]  nPC_sel;
    logic [1:0]  ExtOp;
    logic [2:0]  ALUctr;
    logic        md_start, md_op, md_busy;
    logic [2:0]  state;
    logic        instr_done;

    int errors = 0;
    int checks = 0;

    mc_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .mem_rdy(mem_rdy), .zero(zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .A3(A3), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .hilo_sel(hilo_sel),
        .nPC_sel(nPC_sel), .ExtOp(ExtOp), .ALUctr(ALUctr), .md_start(md_start),
        .md_op(md_op), .md_busy(md_busy), .state(state), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the edge; the extra #1 after input changes lets comb logic settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; mem_rdy = 1'b0; Instr = 32'h0; zero = 1'b0;
        cyc(); cyc();
        check("rst_state", state, 0);
        check("rst_busy", md_busy, 0);
        mem_rdy = 1'b1; #1;
        check("rst_irwrite_gated", IRWrite, 0);
        check("rst_pcwrite_gated", PCWrite, 0);

        // 1: sw stalled in MEM, then reset mid-access
        reset = 1'b0; Instr = I_SW; #1;
        check("sw_fetch_ir", IRWrite, 1);
        cyc(); check("sw_decode", state, 1);
        cyc(); check("sw_exe", state, 2);
        cyc(); mem_rdy = 1'b0; #1;
        check("sw_mem_state", state, 3);
        check("sw_mem_wr", MemWrite, 1);
        check("sw_mem_done", instr_done, 0);
        cyc(); check("sw_mem_hold", state, 3);
        check("sw_mem_wr2", MemWrite, 1);
        reset = 1'b1; #1;
        check("sw_rst_memwrite", MemWrite, 0);
        check("sw_rst_done", instr_done, 0);
        cyc();
        check("sw_rst_state", state, 0);
        check("sw_rst_memwrite_after", MemWrite, 0);
        check("sw_rst_busy", md_busy, 0);
        reset = 1'b0; #1;
        check("fetch_wait_ir", IRWrite, 0);
        cyc(); check("fetch_wait_state", state, 0);

        // 2: addu, 4 cycles
        Instr = I_ADDU; mem_rdy = 1'b1; #1;
        check("addu_fetch_ir", IRWrite, 1);
        check("addu_fetch_pc", PCWrite, 1);
        check("addu_fetch_a3_zero", A3, 0);
        cyc(); check("addu_decode", state, 1);
        cyc(); check("addu_exe", state, 2);
        check("addu_exe_regwrite", RegWrite, 0);
        cyc(); check("addu_wb", state, 4);
        check("addu_wb_regwrite", RegWrite, 1);
        check("addu_wb_a3", A3, 3);
        check("addu_wb_memtoreg", MemtoReg, 0);
        check("addu_wb_aluctr", ALUctr, 0);
        check("addu_wb_done", instr_done, 1);
        cyc(); check("addu_back_fetch", state, 0);
        check("addu_regwrite_off", RegWrite, 0);

        // 3: lw with 3 not-ready MEM cycles, 8 cycles total
        Instr = I_LW; #1;
        cyc(); cyc();
        check("lw_exe", state, 2);
        check("lw_exe_alusrc", ALUSrc, 1);
        cyc(); mem_rdy = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("lw_mem_hold", state, 3);
            check("lw_mem_nowrite", MemWrite, 0);
            cyc();
        end
        mem_rdy = 1'b1; #1;
        check("lw_mem_ready", state, 3);
        cyc();
        check("lw_wb", state, 4);
        check("lw_wb_memtoreg", MemtoReg, 1);
        check("lw_wb_a3", A3, 5);
        check("lw_wb_extop", ExtOp, 1);
        check("lw_wb_regwrite", RegWrite, 1);
        check("lw_wb_done", instr_done, 1);
        cyc();

        // 4: beq taken, then not taken
        Instr = I_BEQ; zero = 1'b1; #1;
        cyc(); cyc();
        check("beq_t_state", state, 2);
        check("beq_t_npc", nPC_sel, 1);
        check("beq_t_pcwrite", PCWrite, 1);
        check("beq_t_aluctr", ALUctr, 3);
        check("beq_t_done", instr_done, 1);
        cyc(); check("beq_t_fetch", state, 0);
        zero = 1'b0; #1;
        cyc(); cyc();
        check("beq_n_pcwrite", PCWrite, 0);
        check("beq_n_npc", nPC_sel, 0);
        check("beq_n_done", instr_done, 1);
        cyc();

        // 5: div, addu overlapping, then mfhi stalls until the counter drains
        Instr = I_DIV; #1;
        cyc(); cyc();
        check("div_start", md_start, 1);
        check("div_op", md_op, 1);
        check("div_busy_pre", md_busy, 0);
        check("div_done", instr_done, 1);
        cyc();
        check("div_busy_1", md_busy, 1);
        check("div_start_once", md_start, 0);
        Instr = I_ADDU; #1;
        cyc(); check("ov_addu_decode", state, 1);
        cyc(); check("ov_addu_exe", state, 2);
        cyc(); check("ov_addu_wb", state, 4);
        check("ov_addu_regwrite", RegWrite, 1);
        check("ov_addu_busy", md_busy, 1);
        cyc();
        Instr = I_MFHI; #1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            check("mfhi_hold_state", state, 1);
            check("mfhi_hold_busy", md_busy, 1);
            check("mfhi_hold_regwrite", RegWrite, 0);
            cyc();
        end
        check("mfhi_release_busy", md_busy, 0);
        check("mfhi_release_state", state, 1);
        cyc();
        check("mfhi_wb", state, 4);
        check("mfhi_wb_memtoreg", MemtoReg, 3);
        check("mfhi_wb_hilo", hilo_sel, 1);
        check("mfhi_wb_a3", A3, 4);
        check("mfhi_wb_regwrite", RegWrite, 1);
        cyc();

        // 6: back-to-back mult
        Instr = I_MULT; #1;
        cyc(); cyc();
        check("mult1_start", md_start, 1);
        check("mult1_op", md_op, 0);
        cyc(); cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            check("mult2_hold_state", state, 2);
            check("mult2_hold_nostart", md_start, 0);
            check("mult2_hold_busy", md_busy, 1);
            cyc();
        end
        check("mult2_busy_clear", md_busy, 0);
        check("mult2_start", md_start, 1);
        check("mult2_done", instr_done, 1);
        cyc();
        check("mult2_busy_again", md_busy, 1);

        // jumps, undefined encoding and immediate decodes
        Instr = I_JAL; #1;
        cyc();
        check("jal_pcwrite", PCWrite, 1);
        check("jal_npc", nPC_sel, 2);
        check("jal_regwrite", RegWrite, 1);
        check("jal_a3", A3, 31);
        check("jal_memtoreg", MemtoReg, 2);
        check("jal_done", instr_done, 1);
        cyc();
        Instr = I_JR; #1;
        cyc();
        check("jr_npc", nPC_sel, 3);
        check("jr_regwrite", RegWrite, 0);
        check("jr_done", instr_done, 1);
        cyc();
        Instr = I_UND; #1;
        cyc();
        check("und_done", instr_done, 1);
        check("und_pcwrite", PCWrite, 0);
        cyc(); check("und_fetch", state, 0);
        Instr = I_ORI; #1;
        cyc();
        check("ori_alusrc", ALUSrc, 1);
        check("ori_aluctr", ALUctr, 2);
        check("ori_extop", ExtOp, 0);
        check("ori_a3", A3, 7);
        cyc(); cyc(); cyc();
        Instr = I_LUI; #1;
        cyc();
        check("lui_extop", ExtOp, 2);
        check("lui_a3", A3, 8);
        cyc(); cyc();
        check("lui_wb", state, 4);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
